// File: rtl/mem_wb_pkg.sv
// Shared CPU defines: stall vector layout and datapath widths for the MEM/WB stage.
package mem_wb_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam int REG_AW    = 5;
    localparam int DATA_W    = 32;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO registers with a bypass so a write in flight is visible this cycle.
module hilo_reg
    import mem_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (we) begin
            hi_reg <= hi_i;
            lo_reg <= lo_i;
        end
    end

    assign hi_o = we ? hi_i : hi_reg;
    assign lo_o = we ? lo_i : lo_reg;

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with flush/stall control, feeding the HI/LO register file.
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [REG_AW-1:0]  mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    output logic [REG_AW-1:0]  wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o
);

    logic bubble;
    logic capture;

    // MEM stalled while WB advances must not replay the MEM instruction twice.
    assign bubble  = flush || (stall[STALL_MEM] && !stall[STALL_WB]);
    assign capture = !stall[STALL_MEM];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || bubble) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
            wb_whilo <= 1'b0;
            wb_hi    <= '0;
            wb_lo    <= '0;
        end else if (capture) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
        end
    end

    // The committed WB write updates HI/LO even on a flush edge; held writes are idempotent.
    hilo_reg u_hilo_reg (
        .clk   (clk),
        .reset (reset),
        .we    (wb_whilo),
        .hi_i  (wb_hi),
        .lo_i  (wb_lo),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL have the following ports, one per line:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  6  pipeline stall vector; bit 4 = MEM held, bit 5 = WB held.
- flush  input  1  exception flush; squashes the MEM->WB transfer.
- mem_wd  input  5  GPR destination address from MEM.
- mem_wreg  input  1  GPR write enable from MEM.
- mem_wdata  input  32  GPR write data from MEM.
- mem_whilo  input  1  HI/LO write enable from MEM.
- mem_hi  input  32  HI write value from MEM.
- mem_lo  input  32  LO write value from MEM.
- wb_wd  output  5  registered GPR destination address to the register file.
- wb_wreg  output  1  registered GPR write enable.
- wb_wdata  output  32  registered GPR write data.
- wb_whilo  output  1  registered HI/LO write enable.
- wb_hi  output  32  registered HI value.
- wb_lo  output  32  registered LO value.
- hi_o  output  32  architectural HI, with WB-stage bypass applied.
- lo_o  output  32  architectural LO, with WB-stage bypass applied.

Function
REQ-002 The wb_* outputs SHALL be registers updated only on the rising edge of clk, or asynchronously by reset.
REQ-003 At each edge, flush=1 SHALL load a bubble: all wb_* = 0. Flush has priority over stall.
REQ-004 Otherwise, stall[4]=1 with stall[5]=0 SHALL load a bubble (all wb_* = 0).
REQ-005 Otherwise, stall[4]=0 SHALL capture mem_* into wb_* (one-cycle latency).
REQ-006 Otherwise (stall[4]=1 and stall[5]=1), wb_* SHALL hold their values.
REQ-007 Internal registers hi_reg and lo_reg (32 bits each) SHALL be loaded from wb_hi and wb_lo at an edge where wb_whilo=1, irrespective of stall and flush.
REQ-008 A HI/LO write held over several cycles by stall[5] SHALL rewrite the same value; the repeated write is idempotent by design.
REQ-009 hi_o and lo_o SHALL be combinational:
- when wb_whilo=1: hi_o = wb_hi and lo_o = wb_lo (bypass);
- otherwise: hi_o = hi_reg and lo_o = lo_reg.
REQ-010 At an edge where flush=1 and wb_whilo=1, the already-committed WB write SHALL still update hi_reg/lo_reg; only the incoming MEM instruction is squashed.
REQ-011 No width conversion SHALL occur; all data paths are passed bit-exact.
REQ-012 When wb_wreg=0, wb_wd and wb_wdata are don't-care downstream but SHALL still follow REQ-003 to REQ-006.

Reset
REQ-013 reset=0 SHALL immediately and asynchronously clear all wb_*, hi_reg and lo_reg to 0; hi_o and lo_o then read 0.
REQ-014 Reset asserted mid-operation SHALL discard any pending HI/LO write.
REQ-015 The first capture SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-016 The stall bit indices (MEM=4, WB=5), the register-address width (5) and the data width (32) SHALL live in the shared CPU defines package.
REQ-017 hi_reg/lo_reg and their bypass mux SHALL be a sub-module named hilo_reg (ports: clk, reset, we, hi_i, lo_i, hi_o, lo_o).
REQ-018 The pipeline register SHALL be in the top level of mem_wb.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Capture: mem_wd=5'd3, mem_wreg=1, mem_wdata=32'hDEADBEEF, stall=0 -> after one edge wb_wd=3, wb_wreg=1, wb_wdata=32'hDEADBEEF.
- HI/LO commit and bypass: mem_whilo=1, mem_hi=32'h11, mem_lo=32'h22 -> edge 1: hi_o=32'h11 via bypass; then mem_whilo=0 -> edge 2: hi_reg=32'h11, lo_o=32'h22 via register.
- Stall: stall=6'b011111 -> wb_* all 0 after edge; stall=6'b111111 -> wb_* hold prior values across 3 edges.
- Flush priority: flush=1 with stall=6'b111111 -> wb_* = 0; a pending wb_whilo=1 with wb_hi=32'h5 still yields hi_o=32'h5 after the edge.
- Async reset: assert reset=0 mid-cycle with hi_reg=32'hA5A5A5A5 -> hi_o=0 and all wb_* = 0 before the next edge; first capture occurs on the edge after release.
